traffic_phase_decoder: RTL and testbench

// - Sits directly downstream of the down-counter stage. Consumes its count and 2-bit phase value.
// - Drives the NS/EW lamp outputs, the pedestrian WALK lamp and a two-digit 7-segment countdown.
// - Owns the restart request (light_out_time) fed back to the counter, for power-up, night mode and fault recovery.
// - Detects illegal phase sequences from the counter.

---
 rtl/traffic_phase_decoder.sv | 257 +++++++++++++++++++++++++
 tb/tb_traffic_phase_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_decoder.sv
// traffic_phase_decoder: turns the down-counter's count/phase into lamps,
// WALK, a two-digit countdown, the counter restart request and a fault flag.
//
// Ports:
//   clk, reset (async, active-low)
//   count_in [BITS-1:0], phase_in [1:0]   counter value and phase
//   hold_in, ped_req, night_mode          freeze, pedestrian button, night
//   ns_light, ew_light [2:0] {R,Y,G}      lamp drives
//   walk                                  pedestrian WALK lamp
//   seg_tens, seg_ones [6:0] {g..a}       countdown digits, active-high
//   light_out_time                        1 = counter clears to 0
//   fault                                 sticky illegal-phase flag
module traffic_phase_decoder #(
    parameter int BITS       = 5,
    parameter int BLINK_DIV  = 2,
    parameter int WALK_BLINK = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] count_in,
    input  logic [1:0]      phase_in,
    input  logic            hold_in,
    input  logic            ped_req,
    input  logic            night_mode,
    output logic [2:0]      ns_light,
    output logic [2:0]      ew_light,
    output logic            walk,
    output logic [6:0]      seg_tens,
    output logic [6:0]      seg_ones,
    output logic            light_out_time,
    output logic            fault
);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_NIGHT,
        S_FAULT
    } state_t;

    localparam int         CW        = BITS + 4;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [2:0] LAMP_R    = 3'b100;
    localparam logic [2:0] LAMP_Y    = 3'b010;
    localparam logic [2:0] LAMP_G    = 3'b001;

    function automatic logic [6:0] seg7(input logic [CW-1:0] d);
        logic [6:0] s;
        s = SEG_DASH;
        if (d <= CW'(9)) begin
            case (d[3:0])
                4'd0:    s = 7'h3F;
                4'd1:    s = 7'h06;
                4'd2:    s = 7'h5B;
                4'd3:    s = 7'h4F;
                4'd4:    s = 7'h66;
                4'd5:    s = 7'h6D;
                4'd6:    s = 7'h7D;
                4'd7:    s = 7'h07;
                4'd8:    s = 7'h7F;
                4'd9:    s = 7'h6F;
                default: s = SEG_DASH;
            endcase
        end
        return s;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  phase_prev_q, phase_prev_d;
    logic        first_q, first_d;
    logic        ped_pending_q, ped_pending_d;
    logic        walk_on_q, walk_on_d;
    logic [3:0]  div_q, div_d;
    logic        blink_q, blink_d;
    logic [2:0]  ns_q, ns_d;
    logic [2:0]  ew_q, ew_d;
    logic        walk_q, walk_d;
    logic [6:0]  tens_q, tens_d;
    logic [6:0]  ones_q, ones_d;
    logic        lot_q, lot_d;
    logic        fault_q, fault_d;

    logic [CW-1:0] cnt_w;
    logic [CW-1:0] tens_w;
    logic [CW-1:0] ones_w;
    logic [1:0]    phase_step;
    logic          cnt_nz;
    logic          illegal;
    logic          ph2_entry;
    logic          walk_blink_zone;

    always_comb begin
        cnt_w           = CW'(count_in);
        tens_w          = cnt_w / CW'(10);
        ones_w          = cnt_w % CW'(10);
        cnt_nz          = |count_in;
        // A step of 2 or 3 (mod 4) is a skipped or reversed phase.
        phase_step      = phase_in - phase_prev_q;
        illegal         = cnt_nz & ~first_q & phase_step[1];
        ph2_entry       = (phase_in == 2'd2) && (phase_prev_q != 2'd2);
        walk_blink_zone = count_in <= BITS'(WALK_BLINK);
    end

    always_comb begin
        state_d       = state_q;
        phase_prev_d  = phase_prev_q;
        first_d       = first_q;
        ped_pending_d = ped_pending_q;
        walk_on_d     = walk_on_q;
        ns_d          = ns_q;
        ew_d          = ew_q;
        walk_d        = walk_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        lot_d         = lot_q;
        fault_d       = fault_q;

        // Free-running blink divider, unaffected by hold.
        div_d   = div_q + 4'd1;
        blink_d = blink_q;
        if (div_q == 4'(BLINK_DIV - 1)) begin
            div_d   = 4'd0;
            blink_d = ~blink_q;
        end

        if (!hold_in) begin
            ns_d   = LAMP_R;
            ew_d   = LAMP_R;
            walk_d = 1'b0;
            tens_d = SEG_DASH;
            ones_d = SEG_DASH;
            lot_d  = 1'b1;

            unique case (state_q)
                S_INIT: begin
                    state_d = S_RUN;
                    lot_d   = 1'b0;
                end
                S_RUN: begin
                    if (cnt_nz) begin
                        phase_prev_d = phase_in;
                        first_d      = 1'b0;
                    end
                    if (illegal) begin
                        state_d   = S_FAULT;
                        fault_d   = 1'b1;
                        walk_on_d = 1'b0;
                        ns_d      = {blink_d, 2'b00};
                        ew_d      = {blink_d, 2'b00};
                    end else if (night_mode) begin
                        state_d   = S_NIGHT;
                        walk_on_d = 1'b0;
                        ns_d      = {1'b0, blink_d, 1'b0};
                        ew_d      = {1'b0, blink_d, 1'b0};
                    end else begin
                        lot_d = 1'b0;
                        if (cnt_nz) begin
                            // Grant clears before the new request below,
                            // so a same-clk press waits a full round.
                            if (ph2_entry && ped_pending_q) begin
                                walk_on_d     = 1'b1;
                                ped_pending_d = 1'b0;
                            end
                            if (phase_in != 2'd2) begin
                                walk_on_d = 1'b0;
                            end
                            unique case (phase_in)
                                2'd0: begin
                                    ns_d = LAMP_G;
                                    ew_d = LAMP_R;
                                end
                                2'd1: begin
                                    ns_d = LAMP_Y;
                                    ew_d = LAMP_R;
                                end
                                2'd2: begin
                                    ns_d = LAMP_R;
                                    ew_d = LAMP_G;
                                end
                                2'd3: begin
                                    ns_d = LAMP_R;
                                    ew_d = LAMP_Y;
                                end
                            endcase
                            tens_d = (tens_w == '0) ? SEG_BLANK
                                                    : seg7(tens_w);
                            ones_d = seg7(ones_w);
                        end
                        walk_d = walk_on_d
                               & (~walk_blink_zone | blink_d);
                    end
                end
                S_NIGHT: begin
                    if (!night_mode) begin
                        state_d = S_INIT;
                        first_d = 1'b1;
                    end else begin
                        ns_d = {1'b0, blink_d, 1'b0};
                        ew_d = {1'b0, blink_d, 1'b0};
                    end
                end
                S_FAULT: begin
                    ns_d = {blink_d, 2'b00};
                    ew_d = {blink_d, 2'b00};
                end
            endcase
        end

        if (ped_req && state_q != S_FAULT) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            phase_prev_q  <= 2'd0;
            first_q       <= 1'b1;
            ped_pending_q <= 1'b0;
            walk_on_q     <= 1'b0;
            div_q         <= 4'd0;
            blink_q       <= 1'b0;
            ns_q          <= LAMP_R;
            ew_q          <= LAMP_R;
            walk_q        <= 1'b0;
            tens_q        <= SEG_DASH;
            ones_q        <= SEG_DASH;
            lot_q         <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_prev_q  <= phase_prev_d;
            first_q       <= first_d;
            ped_pending_q <= ped_pending_d;
            walk_on_q     <= walk_on_d;
            div_q         <= div_d;
            blink_q       <= blink_d;
            ns_q          <= ns_d;
            ew_q          <= ew_d;
            walk_q        <= walk_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            lot_q         <= lot_d;
            fault_q       <= fault_d;
        end
    end

    assign ns_light       = ns_q;
    assign ew_light       = ew_q;
    assign walk           = walk_q;
    assign seg_tens       = tens_q;
    assign seg_ones       = ones_q;
    assign light_out_time = lot_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_traffic_phase_decoder.sv
// tb_traffic_phase_decoder: directed scenarios plus a randomized counter
// emulation, checked every clk against a cycle-level behavioural model.
module tb_traffic_phase_decoder;

    localparam int BITS       = 5;
    localparam int BLINK_DIV  = 2;
    localparam int WALK_BLINK = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [BITS-1:0] count_in;
    logic [1:0]      phase_in;
    logic            hold_in;
    logic            ped_req;
    logic            night_mode;
    logic [2:0]      ns_light;
    logic [2:0]      ew_light;
    logic            walk;
    logic [6:0]      seg_tens;
    logic [6:0]      seg_ones;
    logic            light_out_time;
    logic            fault;

    traffic_phase_decoder #(
        .BITS       (BITS),
        .BLINK_DIV  (BLINK_DIV),
        .WALK_BLINK (WALK_BLINK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .count_in       (count_in),
        .phase_in       (phase_in),
        .hold_in        (hold_in),
        .ped_req        (ped_req),
        .night_mode     (night_mode),
        .ns_light       (ns_light),
        .ew_light       (ew_light),
        .walk           (walk),
        .seg_tens       (seg_tens),
        .seg_ones       (seg_ones),
        .light_out_time (light_out_time),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 INIT, 1 RUN, 2 NIGHT, 3 FAULT.
    int         m_mode;
    int         m_cyc;
    int         m_prev;
    bit         m_first;
    bit         m_pend;
    bit         m_won;
    logic [2:0] e_ns, e_ew;
    logic       e_walk, e_lot, e_fault;
    logic [6:0] e_tens, e_ones;
    logic [6:0] seg_tab [10];
    logic [2:0] ns_tab [4];
    logic [2:0] ew_tab [4];

    int g_ph, g_cnt;
    bit g_night, r_hold, r_ped;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_cyc   = 0;
        m_prev  = 0;
        m_first = 1'b1;
        m_pend  = 1'b0;
        m_won   = 1'b0;
        e_ns    = 3'b100;
        e_ew    = 3'b100;
        e_walk  = 1'b0;
        e_tens  = 7'h40;
        e_ones  = 7'h40;
        e_lot   = 1'b1;
        e_fault = 1'b0;
    endtask

    task automatic model_edge();
        int  c, ph, old_mode;
        bit  blink, ill, entry;
        m_cyc++;
        blink    = ((m_cyc / BLINK_DIV) % 2) == 1;
        c        = int'(count_in);
        ph       = int'(phase_in);
        old_mode = m_mode;
        if (!hold_in) begin
            e_ns   = 3'b100;
            e_ew   = 3'b100;
            e_walk = 1'b0;
            e_tens = 7'h40;
            e_ones = 7'h40;
            e_lot  = 1'b1;
            case (m_mode)
                0: begin
                    m_mode = 1;
                    e_lot  = 1'b0;
                end
                1: begin
                    ill   = (c != 0) && !m_first
                            && (((ph - m_prev + 4) % 4) > 1);
                    entry = (ph == 2) && (m_prev != 2);
                    if (c != 0) begin
                        m_prev  = ph;
                        m_first = 1'b0;
                    end
                    if (ill) begin
                        m_mode  = 3;
                        e_fault = 1'b1;
                        m_won   = 1'b0;
                        e_ns    = blink ? 3'b100 : 3'b000;
                        e_ew    = e_ns;
                    end else if (night_mode) begin
                        m_mode = 2;
                        m_won  = 1'b0;
                        e_ns   = blink ? 3'b010 : 3'b000;
                        e_ew   = e_ns;
                    end else begin
                        e_lot = 1'b0;
                        if (c != 0) begin
                            if (entry && m_pend) begin
                                m_won  = 1'b1;
                                m_pend = 1'b0;
                            end
                            if (ph != 2) m_won = 1'b0;
                            e_ns   = ns_tab[ph];
                            e_ew   = ew_tab[ph];
                            e_tens = (c / 10 == 0) ? 7'h00
                                                   : seg_tab[c / 10];
                            e_ones = seg_tab[c % 10];
                        end
                        e_walk = m_won && (c > WALK_BLINK || blink);
                    end
                end
                2: begin
                    if (!night_mode) begin
                        m_mode  = 0;
                        m_first = 1'b1;
                    end else begin
                        e_ns = blink ? 3'b010 : 3'b000;
                        e_ew = e_ns;
                    end
                end
                default: begin
                    e_ns = blink ? 3'b100 : 3'b000;
                    e_ew = e_ns;
                end
            endcase
        end
        if (ped_req && old_mode != 3) m_pend = 1'b1;
    endtask

    task automatic compare_all();
        chk("ns",    8'(ns_light),       8'(e_ns));
        chk("ew",    8'(ew_light),       8'(e_ew));
        chk("walk",  8'(walk),           8'(e_walk));
        chk("tens",  8'(seg_tens),       8'(e_tens));
        chk("ones",  8'(seg_ones),       8'(e_ones));
        chk("lot",   8'(light_out_time), 8'(e_lot));
        chk("fault", 8'(fault),          8'(e_fault));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input int ph, input int cnt, input bit ped,
                         input bit nt, input bit hd);
        phase_in   = 2'(ph);
        count_in   = BITS'(cnt);
        ped_req    = ped;
        night_mode = nt;
        hold_in    = hd;
        step();
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        count_in   = '0;
        phase_in   = 2'd0;
        hold_in    = 1'b0;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        chk("rst_ns",    8'(ns_light),       8'h04);
        chk("rst_tens",  8'(seg_tens),       8'h40);
        chk("rst_lot",   8'(light_out_time), 8'h01);
        chk("rst_fault", 8'(fault),          8'h00);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_lot", 8'(light_out_time), 8'h01);
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        ns_tab  = '{3'b001, 3'b010, 3'b100, 3'b100};
        ew_tab  = '{3'b100, 3'b100, 3'b001, 3'b010};

        do_reset();
        drive(0, 0, 0, 0, 0);
        chk("init_lot", 8'(light_out_time), 8'h00);
        chk("idle_ns",  8'(ns_light),       8'h04);

        drive(0, 26, 1, 0, 0);
        chk("p0_ns",   8'(ns_light), 8'h01);
        chk("seg26_t", 8'(seg_tens), 8'h5B);
        chk("seg26_o", 8'(seg_ones), 8'h7D);
        for (int c = 25; c >= 1; c--) drive(0, c, 0, 0, 0);
        drive(1, 9, 0, 0, 0);
        chk("p1_ns",  8'(ns_light), 8'h02);
        chk("p1_ew",  8'(ew_light), 8'h04);
        chk("seg9_t", 8'(seg_tens), 8'h00);
        chk("seg9_o", 8'(seg_ones), 8'h6F);
        for (int c = 8; c >= 1; c--) drive(1, c, 0, 0, 0);
        drive(2, 26, 0, 0, 0);
        chk("walk_on", 8'(walk),     8'h01);
        chk("p2_ew",   8'(ew_light), 8'h01);
        for (int c = 25; c >= 1; c--) drive(2, c, 0, 0, 0);
        drive(3, 5, 0, 0, 0);
        chk("walk_off", 8'(walk),     8'h00);
        chk("p3_ew",    8'(ew_light), 8'h02);

        drive(0, 10, 0, 0, 0);
        drive(1, 10, 0, 0, 0);
        drive(3, 10, 0, 0, 0);
        chk("fault_set", 8'(fault),          8'h01);
        chk("fault_lot", 8'(light_out_time), 8'h01);
        repeat (6) drive(0, 0, 0, 0, 0);
        chk("fault_sticky", 8'(fault), 8'h01);

        do_reset();
        drive(0, 0, 0, 0, 0);
        drive(0, 20, 0, 0, 0);
        drive(0, 19, 0, 1, 0);
        chk("night_lot", 8'(light_out_time), 8'h01);
        repeat (5) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("ninit_lot", 8'(light_out_time), 8'h01);
        drive(0, 0, 0, 0, 0);
        chk("nrun_lot", 8'(light_out_time), 8'h00);

        drive(0, 15, 0, 0, 0);
        drive(0, 14, 1, 0, 1);
        chk("hold_o", 8'(seg_ones), 8'h6D);
        drive(0, 9, 0, 0, 1);
        chk("hold_t", 8'(seg_tens), 8'h06);
        drive(0, 13, 0, 0, 0);
        drive(1, 5, 0, 0, 0);
        drive(2, 20, 0, 0, 0);
        chk("hold_ped", 8'(walk), 8'h01);

        do_reset();
        g_ph    = 0;
        g_cnt   = 0;
        g_night = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_hold = ($urandom_range(0, 9) == 0);
            r_ped  = ($urandom_range(0, 7) == 0);
            if (g_night) begin
                if ($urandom_range(0, 14) == 0) g_night = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                g_night = 1'b1;
            end
            if (e_lot) begin
                g_cnt = 0;
                g_ph  = 0;
            end else if (r_hold) begin
                if ($urandom_range(0, 1) == 1)
                    g_cnt = int'($urandom_range(1, 31));
            end else if (g_cnt > 1) begin
                g_cnt--;
            end else begin
                if (g_cnt != 0) g_ph = (g_ph + 1) % 4;
                g_cnt = int'($urandom_range(2, 12));
            end
            if (!r_hold && g_cnt != 0 && $urandom_range(0, 299) == 0)
                g_ph = (g_ph + 2) % 4;
            drive(g_ph, g_cnt, r_ped, g_night, r_hold);
            if (e_fault && $urandom_range(0, 29) == 0) begin
                do_reset();
                g_night = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
